rv_regfile_sb: RTL and testbench
================================

Name: rv_regfile_sb

Overview:
- Parametrised integer register file for the NPC core; successor to the single-write, two-read, fixed 32-entry register file.
- Configurable entry count: 16 for RV32E, 32 for RV32I. Configurable data width, read-port count and write-port count.
- Adds a per-register busy scoreboard with a reserve handshake, deterministic multi-write priority, a busy-count output, and optional write-to-read bypass.
- Sits between decode (reads, reserve), writeback (writes) and the hazard unit (busy flags, count).

Parameters:
- XLEN, 32, data width of each register.
- NREG, 16, number of architectural registers; power of two, 2..32.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports; higher index has higher priority.
- AW, $clog2(NREG), address width; derived, not overridden.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- rd_addr  input  NRD*AW  packed read addresses; port i at [i*AW +: AW].
- rd_data  output  NRD*XLEN  packed read data.
- rd_busy  output  NRD  busy flag of each addressed register.
- wr_en  input  NWR  write strobes.
- wr_addr  input  NWR*AW  packed write addresses.
- wr_data  input  NWR*XLEN  packed write data.
- rsv_valid  input  1  reserve request: mark rsv_addr busy.
- rsv_addr  input  AW  register to reserve.
- rsv_ready  output  1  reserve accepted this cycle.
- busy_cnt  output  $clog2(NREG+1)  number of busy registers.

Behaviour:
- Register 0: reads always return 0; writes to it are ignored; it is never busy and never counted.
- Reset (rst high at posedge): all registers 0, all busy bits 0, busy_cnt 0. rst dominates every same-cycle write and reserve.
- Reset mid-operation: any pending reservations are discarded.
- Reads: combinational; rd_data and rd_busy reflect current state (plus bypass, see Optional Feature). After reset, all rd_data = 0.
- Writes: take effect at posedge when wr_en[j]=1 and wr_addr[j]!=0; 1-cycle latency to read.
- Multiple ports writing the same address in one cycle: the highest-index port's data is stored.
- Scoreboard:
  - A write clears the busy bit of its address at posedge. This applies whether or not the bit was set; a write to a non-busy register is legal.
  - rsv_ready = rsv_valid & (rsv_addr==0 | ~busy[rsv_addr]). This is a combinational WAW stall.
  - On handshake (rsv_valid & rsv_ready) with rsv_addr!=0, the busy bit is set at posedge.
  - Reserving x0 is accepted and has no effect.
- Same cycle, same address, write plus accepted reserve: the data is written and the busy bit ends at 1 (reserve wins).
- Reserve of a busy register while a write clears it in the same cycle: rsv_ready is still 0, because it is computed from the pre-edge state. The requester retries next cycle.
- busy_cnt: registered; equals the popcount of the busy bits after each edge. It never exceeds NREG-1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read whose address matches an active same-cycle write (address !=0) returns that write's data, highest-index matching port first.
  - rd_busy for that address reads 0 unless an accepted reserve targets the same address in the same cycle.
- Undefined:
  - Reads return the stored value; new data is visible the cycle after the write.
  - rd_busy reflects stored busy bits only.

Decomposition:
- Package rv_regfile_pkg holds:
  - default XLEN, NREG_RV32E=16, NREG_RV32I=32;
  - function clog2_safe;
  - function popcount for the busy vector.
- One sub-module, rv_regfile_wrsel: a combinational priority selector, shared by the storage write path and the bypass mux. Given wr_en, wr_addr, wr_data and a query address, it returns hit and data.

Test Plan:
- Reset, then read all addresses -> rd_data=0, rd_busy=0, busy_cnt=0. Then write x0=32'hDEADBEEF -> x0 still reads 0.
- Port0 writes x5=32'h11, port1 writes x5=32'h22 in the same cycle -> next cycle x5=32'h22.
- Reserve x3 (rsv_ready=1) -> busy_cnt=1. Reserve x3 again -> rsv_ready=0. Write x3=32'h5 -> busy clears, busy_cnt=0, x3=32'h5.
- Write x7=32'hA with reserve x7 in the same cycle -> x7=32'hA, rd_busy=1, busy_cnt=1.
- REGFILE_BYPASS_EN defined: write x9=32'h99 while reading x9 -> rd_data=32'h99 in the same cycle. Undefined: the old value in that cycle, 32'h99 next cycle.
- Reserve x1, x2, x4, then assert rst with a concurrent write to x1 -> all registers 0, busy_cnt=0.

Source files
------------

// File: rtl/rv_regfile_pkg.sv
// rv_regfile_pkg: shared sizes and helpers for the scoreboarded register file
package rv_regfile_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_RV32E = 16;
  localparam int NREG_RV32I = 32;
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + 6'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/rv_regfile_wrsel.sv
// rv_regfile_wrsel: picks the highest-index write port hitting a non-zero query address
module rv_regfile_wrsel #(
  parameter int XLEN = 32,
  parameter int AW = 4,
  parameter int NWR = 2
) (
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [AW-1:0]       q_addr,
  output logic                hit,
  output logic [XLEN-1:0]     data
);
  always_comb begin
    hit = 1'b0;
    data = '0;
    for (int j = 0; j < NWR; j++)
      if (wr_en[j] && wr_addr[j*AW +: AW] == q_addr && q_addr != '0) begin
        hit = 1'b1;
        data = wr_data[j*XLEN +: XLEN];
      end
  end
endmodule

// File: rtl/rv_regfile_sb.sv
// rv_regfile_sb: multi-port integer register file with busy scoreboard and reserve handshake.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module rv_regfile_sb
  import rv_regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = NREG_RV32E,
  parameter int NRD = 2,
  parameter int NWR = 2,
  localparam int AW = clog2_safe(NREG),
  localparam int CW = clog2_safe(NREG + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                rsv_valid,
  input  logic [AW-1:0]       rsv_addr,
  output logic                rsv_ready,
  output logic [CW-1:0]       busy_cnt
);
  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   busy_cnt_q;
  logic [NREG-1:0] wr_hit;
  logic [XLEN-1:0] wr_val [NREG];
  assign rsv_ready = rsv_valid & (rsv_addr == '0 | ~busy_q[rsv_addr]);
  assign busy_cnt = busy_cnt_q;
  // One selector per register keeps x0 permanently unwritten and zero.
  for (genvar r = 0; r < NREG; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign wr_hit[r] = 1'b0;
      assign wr_val[r] = '0;
    end else begin : g_sel
      rv_regfile_wrsel #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_sel (
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .q_addr(AW'(r)), .hit(wr_hit[r]), .data(wr_val[r])
      );
    end
    always_ff @(posedge clk)
      if (rst) regs_q[r] <= '0;
      else if (wr_hit[r]) regs_q[r] <= wr_val[r];
  end
  // Reserve is applied after the write clear so a same-cycle reserve wins.
  always_comb begin
    busy_d = busy_q & ~wr_hit;
    if (rsv_ready && rsv_addr != '0) busy_d[rsv_addr] = 1'b1;
  end
  always_ff @(posedge clk)
    if (rst) begin
      busy_q <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      busy_cnt_q <= CW'(popcount(32'(busy_d)));
    end
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = rd_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    logic byp_hit;
    logic [XLEN-1:0] byp_data;
    rv_regfile_wrsel #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_byp (
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .q_addr(ra), .hit(byp_hit), .data(byp_data)
    );
    assign rd_data[i*XLEN +: XLEN] = byp_hit ? byp_data : regs_q[ra];
    assign rd_busy[i] = byp_hit ? (rsv_ready && rsv_addr == ra) : busy_q[ra];
`else
    assign rd_data[i*XLEN +: XLEN] = regs_q[ra];
    assign rd_busy[i] = busy_q[ra];
`endif
  end
endmodule

// File: tb/tb_rv_regfile_sb.sv
// tb_rv_regfile_sb: scoreboard bench comparing rv_regfile_sb against a sequential reference model
module tb_rv_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREG = 16;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW = 4;
  localparam int CW = 5;

  typedef struct {
    logic [NRD*XLEN-1:0] d;
    logic [NRD-1:0]      b;
    logic                rr;
    int                  cnt;
    string               tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en = '0;
  logic [NWR*AW-1:0]   wr_addr = '0;
  logic [NWR*XLEN-1:0] wr_data = '0;
  logic                rsv_valid = 1'b0;
  logic [AW-1:0]       rsv_addr = '0;
  logic                rsv_ready;
  logic [CW-1:0]       busy_cnt;

  int n_chk = 0;
  int n_fail = 0;
  exp_t q[$];

  logic [XLEN-1:0] mem [NREG];
  bit              bsy [NREG];
  bit              model_ok = 0;

  always #5 clk = ~clk;

  rv_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready), .busy_cnt(busy_cnt)
  );

  // Drive one cycle of inputs, predict the combinational/registered outputs, then advance the model.
  task automatic step(input string tag, input logic r, input logic [NWR-1:0] we,
                      input logic [NWR*AW-1:0] wa, input logic [NWR*XLEN-1:0] wd,
                      input logic rv, input logic [AW-1:0] ra, input logic [NRD*AW-1:0] rda);
    exp_t e;
    bit ready;
    int a, w;
    @(posedge clk);
    #1;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_valid = rv; rsv_addr = ra; rd_addr = rda;
    ready = rv && (ra == 0 || !bsy[ra]);
    if (model_ok) begin
      e.tag = tag;
      e.rr = ready;
      e.cnt = 0;
      for (int k = 0; k < NREG; k++) e.cnt += int'(bsy[k]);
      for (int p = 0; p < NRD; p++) begin
        a = int'(rda[p*AW +: AW]);
        e.d[p*XLEN +: XLEN] = (a == 0) ? '0 : mem[a];
        e.b[p] = bsy[a];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NWR; j++)
          if (we[j] && int'(wa[j*AW +: AW]) == a && a != 0) begin
            e.d[p*XLEN +: XLEN] = wd[j*XLEN +: XLEN];
            e.b[p] = ready && int'(ra) == a;
          end
`endif
      end
      q.push_back(e);
    end
    if (r) begin
      for (int k = 0; k < NREG; k++) begin mem[k] = '0; bsy[k] = 0; end
      model_ok = 1;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        w = int'(wa[j*AW +: AW]);
        if (we[j] && w != 0) begin mem[w] = wd[j*XLEN +: XLEN]; bsy[w] = 0; end
      end
      if (ready && ra != 0) bsy[ra] = 1;
    end
  endtask

  task automatic rd(input string tag, input int a);
    step(tag, 0, '0, '0, '0, 0, '0, {AW'(a), AW'(a)});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk += 4;
      if (rd_data !== e.d) begin
        n_fail++;
        $display("FAIL %s rd_data got %h exp %h", e.tag, rd_data, e.d);
      end
      if (rd_busy !== e.b) begin
        n_fail++;
        $display("FAIL %s rd_busy got %b exp %b", e.tag, rd_busy, e.b);
      end
      if (rsv_ready !== e.rr) begin
        n_fail++;
        $display("FAIL %s rsv_ready got %b exp %b", e.tag, rsv_ready, e.rr);
      end
      if (busy_cnt !== CW'(e.cnt)) begin
        n_fail++;
        $display("FAIL %s busy_cnt got %0d exp %0d", e.tag, busy_cnt, e.cnt);
      end
    end
  end

  initial begin
    step("rst", 1, '0, '0, '0, 0, '0, '0);
    for (int a = 0; a < NREG; a++) rd("rst_rd", a);
    step("wr_x0", 0, 2'b01, {4'd0, 4'd0}, {32'h0, 32'hDEADBEEF}, 0, '0, {4'd0, 4'd0});
    rd("rd_x0", 0);
    step("wr_x5_dual", 0, 2'b11, {4'd5, 4'd5}, {32'h22, 32'h11}, 0, '0, '0);
    rd("rd_x5", 5);
    step("rsv_x3", 1'b0, '0, '0, '0, 1, 4'd3, {4'd3, 4'd3});
    step("rsv_x3_again", 0, '0, '0, '0, 1, 4'd3, {4'd3, 4'd3});
    step("wr_x3", 0, 2'b01, {4'd0, 4'd3}, {32'h0, 32'h5}, 0, '0, {4'd3, 4'd3});
    rd("rd_x3", 3);
    step("wr_rsv_x7", 0, 2'b10, {4'd7, 4'd0}, {32'hA, 32'h0}, 1, 4'd7, {4'd7, 4'd7});
    rd("rd_x7", 7);
    step("wr_x9_old", 0, 2'b01, {4'd0, 4'd9}, {32'h0, 32'h55}, 0, '0, '0);
    step("wr_x9_byp", 0, 2'b01, {4'd0, 4'd9}, {32'h0, 32'h99}, 0, '0, {4'd9, 4'd9});
    rd("rd_x9", 9);
    step("rsv_x1", 0, '0, '0, '0, 1, 4'd1, '0);
    step("rsv_x2", 0, '0, '0, '0, 1, 4'd2, '0);
    step("rsv_x4", 0, '0, '0, '0, 1, 4'd4, {4'd1, 4'd2});
    step("rst_wr_x1", 1, 2'b01, {4'd0, 4'd1}, {32'h0, 32'h77}, 1, 4'd5, {4'd1, 4'd4});
    rd("post_rst_x1", 1);
    rd("post_rst_x5", 5);
    for (int n = 0; n < 400; n++) begin
      logic [NWR*AW-1:0] wa;
      logic [NWR*XLEN-1:0] wd;
      logic [NRD*AW-1:0] rda;
      for (int j = 0; j < NWR; j++) begin
        wa[j*AW +: AW] = AW'($urandom_range(0, NREG - 1));
        wd[j*XLEN +: XLEN] = $urandom;
      end
      for (int p = 0; p < NRD; p++) rda[p*AW +: AW] = AW'($urandom_range(0, NREG - 1));
      step("rand", $urandom_range(0, 59) == 0, NWR'($urandom), wa, wd,
           1'($urandom), AW'($urandom_range(0, NREG - 1)), rda);
    end
    rd("final", 0);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
